expr_vector_sequencer: RTL and testbench
========================================

// Module: expr_vector_sequencer
// PURPOSE
//  Stimulus sequencer and checker for the 12-operand / 90-bit combinational expression datapaths.
//  - Drives LFSR-generated operand vectors into two implementations of one expression:
//    the DUT (y_dut) and the golden model (y_ref).
//  - Waits a programmable settle time, compares the two 90-bit results and counts mismatches.
//  - Records the index of the first failing vector and folds every y_dut into a 32-bit MISR signature.
//  - Sits between the regression control registers and the expression block(s) under test.
// PARAMETERS
//  SETTLE_CYCLES  2   cycles held in SETTLE per vector; legal range 1..255
//  IDX_W          16  width of vector count / index
// PORTS
//  clk               in   1      single clock, rising edge
//  rst_n             in   1      asynchronous, active-low reset
//  start             in   1      run request; accepted only in IDLE
//  num_vectors       in   IDX_W  vectors to run; sampled on accepted start
//  seed              in   32     LFSR seed; sampled on accepted start
//  opnd_a            out  30     {a5[29:24],a4[23:19],a3[18:15],a2[14:9],a1[8:4],a0[3:0]}
//  opnd_b            out  30     same packing for b0..b5
//  y_dut             in   90     DUT result
//  y_ref             in   90     golden result
//  busy              out  1      high from accepted start until done pulse (inclusive)
//  done              out  1      one-cycle pulse at end of run
//  mismatch_count    out  IDX_W  vectors where y_dut != y_ref
//  first_fail_valid  out  1      at least one mismatch seen
//  first_fail_idx    out  IDX_W  index of first mismatching vector
//  signature         out  32     MISR over y_dut of all checked vectors
// BEHAVIOUR
//  Reset: every output 0, state IDLE, LFSR 0. Reset mid-run aborts immediately; no done pulse.
//  FSM states: IDLE, APPLY, SETTLE, CHECK, DONE.
//  IDLE
//   - start=1: LFSR <= {seed,~seed} (never all-zero), idx<=0; clear mismatch_count,
//     first_fail_*, signature; busy<=1.
//   - If num_vectors==0 go to DONE, else go to APPLY.
//  APPLY (1 cycle)
//   - opnd_a<=lfsr[29:0], opnd_b<=lfsr[59:30] (registered).
//   - settle counter <= SETTLE_CYCLES; go to SETTLE.
//  SETTLE
//   - Counter decrements each cycle; leave for CHECK in the cycle it reads 1.
//   - Operands stay stable throughout.
//  CHECK (1 cycle)
//   - Compare y_dut vs y_ref (full 90 bits, unsigned equality). On mismatch:
//     mismatch_count++; if !first_fail_valid, capture idx and set first_fail_valid.
//   - signature <= {sig[30:0], sig[31]^sig[21]^sig[1]^sig[0]} ^ y_dut[31:0] ^ y_dut[63:32] ^ {6'b0,y_dut[89:64]}.
//   - Advance LFSR one step.
//   - idx==num_vectors-1 -> DONE; otherwise idx++ and go to APPLY.
//  DONE (1 cycle): done=1, busy=0 next cycle, return to IDLE.
//  LFSR: 64-bit Fibonacci, taps 64,63,61,60, shift toward MSB, feedback into bit 0.
//  Timing
//   - Per-vector cost SETTLE_CYCLES+2 cycles.
//   - Start-accept edge to done pulse is N*(SETTLE_CYCLES+2)+1 cycles.
//   - For N==0 the done pulse is 1 cycle after accept.
//  Boundaries
//   - start while busy is ignored.
//   - mismatch_count cannot overflow (<= num_vectors).
//   - Results hold until the next accepted start.
//   - Operands hold the last vector after DONE.
// STRUCTURE
//  expr_seq_pkg
//   - state enum
//   - OPND_W=30, Y_W=90, SIG_W=32
//   - LFSR_TAPS, MISR_TAPS
//   - operand field offsets/widths
//  Sub-module lfsr64 (load, step, state out); FSM, counters and MISR stay in the top.
// TESTING
//  1. y_ref=y_dut, N=4, S=2, seed=1 -> done 17 cycles after accept; mismatch_count=0; first_fail_valid=0.
//  2. Force y_dut[0] flipped only while idx==2, N=5 -> mismatch_count=1, first_fail_idx=2, first_fail_valid=1.
//  3. N=0, start -> done pulse next cycle, busy high 2 cycles, all counts 0, signature 0.
//  4. Same seed run twice with identical DUT -> identical signature and opnd sequence; seed+1 -> different first opnd_a.
//  5. Assert rst_n low during SETTLE of vector 3 -> all outputs 0 asynchronously, no done; later start runs normally.
//  6. Pulse start again while busy (N=3) -> ignored; exactly one done; mismatch totals unchanged.

Source files
------------

// File: rtl/expr_vector_sequencer_pkg.sv
// Shared types, widths and helper functions for the expression vector sequencer.
package expr_vector_sequencer_pkg;

  localparam int unsigned OPND_W = 30;
  localparam int unsigned Y_W    = 90;
  localparam int unsigned SIG_W  = 32;
  localparam int unsigned LFSR_W = 64;

  // Fibonacci taps 64,63,61,60 expressed as zero-based bit masks.
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 64'hD800_0000_0000_0000;
  // MISR feedback from sig[31], sig[21], sig[1], sig[0].
  localparam logic [SIG_W-1:0]  MISR_TAPS = 32'h8020_0003;

  // Operand packing {x5,x4,x3,x2,x1,x0}: field LSB positions and widths.
  localparam int unsigned OPND_FIELD_LSB [6] = '{0, 4, 9, 15, 19, 24};
  localparam int unsigned OPND_FIELD_W   [6] = '{4, 5, 6, 4, 5, 6};

  typedef enum logic [2:0] {
    StIdle,
    StApply,
    StSettle,
    StCheck,
    StDone
  } state_e;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
  endfunction

  function automatic logic [SIG_W-1:0] misr_next(input logic [SIG_W-1:0] sig,
                                                 input logic [Y_W-1:0]   y);
    return {sig[SIG_W-2:0], ^(sig & MISR_TAPS)} ^ y[31:0] ^ y[63:32] ^ {6'b0, y[89:64]};
  endfunction

endpackage

// File: rtl/expr_vector_sequencer_if.sv
// Control/result and operand/result bus between regression control, sequencer and datapaths.
interface expr_vector_sequencer_if
  import expr_vector_sequencer_pkg::*;
#(
  parameter int unsigned IDX_W = 16
);

  logic             start;
  logic [IDX_W-1:0] num_vectors;
  logic [31:0]      seed;
  logic [OPND_W-1:0] opnd_a;
  logic [OPND_W-1:0] opnd_b;
  logic [Y_W-1:0]   y_dut;
  logic [Y_W-1:0]   y_ref;
  logic             busy;
  logic             done;
  logic [IDX_W-1:0] mismatch_count;
  logic             first_fail_valid;
  logic [IDX_W-1:0] first_fail_idx;
  logic [SIG_W-1:0] signature;

  modport master (
    output start, num_vectors, seed, y_dut, y_ref,
    input  opnd_a, opnd_b, busy, done, mismatch_count, first_fail_valid, first_fail_idx,
           signature
  );

  modport slave (
    input  start, num_vectors, seed, y_dut, y_ref,
    output opnd_a, opnd_b, busy, done, mismatch_count, first_fail_valid, first_fail_idx,
           signature
  );

endinterface

// File: rtl/expr_vector_sequencer_lfsr64.sv
// 64-bit Fibonacci LFSR with synchronous load (priority) and single-step advance.
module lfsr64
  import expr_vector_sequencer_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic [LFSR_W-1:0] seed_i,
  input  logic              step_i,
  output logic [LFSR_W-1:0] state_o
);

  logic [LFSR_W-1:0] state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (load_i) begin
      state_d = seed_i;
    end else if (step_i) begin
      state_d = lfsr_next(state_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= '0;
    end else begin
      state_q <= state_d;
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/expr_vector_sequencer.sv
// Applies LFSR operand vectors to DUT and golden datapaths, checks results, builds a MISR.
module expr_vector_sequencer
  import expr_vector_sequencer_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned IDX_W         = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  expr_vector_sequencer_if.slave bus_io
);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [IDX_W-1:0]  nvec_q, nvec_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [OPND_W-1:0] opa_q, opa_d;
  logic [OPND_W-1:0] opb_q, opb_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [IDX_W-1:0]  mcount_q, mcount_d;
  logic              ffv_q, ffv_d;
  logic [IDX_W-1:0]  ffi_q, ffi_d;
  logic [SIG_W-1:0]  sig_q, sig_d;

  logic              lfsr_load;
  logic              lfsr_step;
  logic [LFSR_W-1:0] lfsr_state;
  logic              unused_lfsr_msbs;

  lfsr64 u_lfsr (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (lfsr_load),
    .seed_i  ({bus_io.seed, ~bus_io.seed}),
    .step_i  (lfsr_step),
    .state_o (lfsr_state)
  );

  assign unused_lfsr_msbs = ^lfsr_state[63:60];

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    nvec_d    = nvec_q;
    cnt_d     = cnt_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    mcount_d  = mcount_q;
    ffv_d     = ffv_q;
    ffi_d     = ffi_q;
    sig_d     = sig_q;
    lfsr_load = 1'b0;
    lfsr_step = 1'b0;

    // busy covers the done pulse cycle, then drops.
    if (done_q) begin
      busy_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        // busy_q is still high during the done pulse; a start there is ignored.
        if (bus_io.start && !busy_q) begin
          lfsr_load = 1'b1;
          idx_d     = '0;
          nvec_d    = bus_io.num_vectors;
          mcount_d  = '0;
          ffv_d     = 1'b0;
          ffi_d     = '0;
          sig_d     = '0;
          busy_d    = 1'b1;
          state_d   = (bus_io.num_vectors == '0) ? StDone : StApply;
        end
      end
      StApply: begin
        opa_d   = lfsr_state[29:0];
        opb_d   = lfsr_state[59:30];
        cnt_d   = 8'(SETTLE_CYCLES);
        state_d = StSettle;
      end
      StSettle: begin
        cnt_d = cnt_q - 8'd1;
        if (cnt_q == 8'd1) begin
          state_d = StCheck;
        end
      end
      StCheck: begin
        if (bus_io.y_dut != bus_io.y_ref) begin
          mcount_d = mcount_q + IDX_W'(1);
          if (!ffv_q) begin
            ffv_d = 1'b1;
            ffi_d = idx_q;
          end
        end
        sig_d     = misr_next(sig_q, bus_io.y_dut);
        lfsr_step = 1'b1;
        if (idx_q == nvec_q - IDX_W'(1)) begin
          state_d = StDone;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = StApply;
        end
      end
      StDone: begin
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      nvec_q   <= '0;
      cnt_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      mcount_q <= '0;
      ffv_q    <= 1'b0;
      ffi_q    <= '0;
      sig_q    <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      nvec_q   <= nvec_d;
      cnt_q    <= cnt_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      mcount_q <= mcount_d;
      ffv_q    <= ffv_d;
      ffi_q    <= ffi_d;
      sig_q    <= sig_d;
    end
  end

  assign bus_io.opnd_a           = opa_q;
  assign bus_io.opnd_b           = opb_q;
  assign bus_io.busy             = busy_q;
  assign bus_io.done             = done_q;
  assign bus_io.mismatch_count   = mcount_q;
  assign bus_io.first_fail_valid = ffv_q;
  assign bus_io.first_fail_idx   = ffi_q;
  assign bus_io.signature        = sig_q;

endmodule

// File: tb/tb_expr_vector_sequencer.sv
// Randomized bench: expression model {a,b,a^b} with injected per-vector DUT errors.
module tb_expr_vector_sequencer;

  localparam int unsigned S    = 2;
  localparam int unsigned IW   = 16;
  localparam int          MAXV = 32;
  localparam int          PER  = S + 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  expr_vector_sequencer_if #(.IDX_W(IW)) bus ();

  expr_vector_sequencer #(
    .SETTLE_CYCLES (S),
    .IDX_W         (IW)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_io (bus)
  );

  // Expected operand stream and per-vector error masks of the current run.
  logic [29:0] ea [MAXV];
  logic [29:0] eb [MAXV];
  logic [89:0] em [MAXV];
  int          cur_n = 0;

  int checks   = 0;
  int failures = 0;

  logic [89:0] yr, msk;
  always_comb begin
    yr  = {bus.opnd_a, bus.opnd_b, bus.opnd_a ^ bus.opnd_b};
    msk = '0;
    for (int i = 0; i < MAXV; i++) begin
      if (i < cur_n && ea[i] == bus.opnd_a && eb[i] == bus.opnd_b) msk = em[i];
    end
    bus.y_ref = yr;
    bus.y_dut = yr ^ msk;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, "_opa"},  64'(bus.opnd_a), 64'd0);
    check_eq({tag, "_opb"},  64'(bus.opnd_b), 64'd0);
    check_eq({tag, "_busy"}, 64'(bus.busy), 64'd0);
    check_eq({tag, "_done"}, 64'(bus.done), 64'd0);
    check_eq({tag, "_mc"},   64'(bus.mismatch_count), 64'd0);
    check_eq({tag, "_ffv"},  64'(bus.first_fail_valid), 64'd0);
    check_eq({tag, "_ffi"},  64'(bus.first_fail_idx), 64'd0);
    check_eq({tag, "_sig"},  64'(bus.signature), 64'd0);
  endtask

  function automatic logic [63:0] step64(input logic [63:0] s);
    return {s[62:0], s[63] ^ s[62] ^ s[60] ^ s[59]};
  endfunction

  // Fills ea/eb/em for a run; err_idx: -1 none, -2 random, >=0 flip y_dut[0] at that index.
  task automatic build_model(input int n, input logic [31:0] sd, input int err_idx,
                             output int mc, output bit ffv, output int ffi,
                             output logic [31:0] sig);
    logic [63:0] s;
    logic [89:0] m, yd;
    s   = {sd, ~sd};
    mc  = 0;
    ffv = 1'b0;
    ffi = 0;
    sig = '0;
    for (int i = 0; i < n; i++) begin
      ea[i] = s[29:0];
      eb[i] = s[59:30];
      m = '0;
      if (err_idx == i) begin
        m = 90'd1;
      end else if (err_idx == -2 && $urandom_range(3, 0) == 0) begin
        m = 90'({$urandom(), $urandom(), $urandom()});
        m[$urandom_range(89, 0)] = 1'b1;
      end
      em[i] = m;
      yd = {ea[i], eb[i], ea[i] ^ eb[i]} ^ m;
      if (m != '0) begin
        mc++;
        if (!ffv) begin
          ffv = 1'b1;
          ffi = i;
        end
      end
      sig = {sig[30:0], sig[31] ^ sig[21] ^ sig[1] ^ sig[0]}
            ^ yd[31:0] ^ yd[63:32] ^ {6'b0, yd[89:64]};
      s = step64(s);
    end
    cur_n = n;
  endtask

  task automatic run(input int n, input logic [31:0] sd, input int err_idx, input int pulse_at,
                     input string tag);
    int          mc, ffi, done_at, extra_done;
    bit          ffv, busy_ok;
    logic [31:0] sig;
    build_model(n, sd, err_idx, mc, ffv, ffi, sig);
    @(negedge clk);
    bus.start       = 1'b1;
    bus.num_vectors = IW'(n);
    bus.seed        = sd;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    check_eq({tag, "_busy_accept"}, 64'(bus.busy), 64'd1);
    done_at = -1;
    busy_ok = 1'b1;
    for (int k = 1; k <= n * PER + 10; k++) begin
      @(posedge clk);
      #1;
      if (k == pulse_at) begin
        bus.start       = 1'b1;
        bus.num_vectors = IW'(7);
        bus.seed        = ~sd;
      end else begin
        bus.start = 1'b0;
      end
      if (k % PER == 2 && k / PER < n) begin
        check_eq({tag, "_opa"}, 64'(bus.opnd_a), 64'(ea[k / PER]));
        check_eq({tag, "_opb"}, 64'(bus.opnd_b), 64'(eb[k / PER]));
      end
      if (bus.done) begin
        done_at = k;
        break;
      end
      if (!bus.busy) busy_ok = 1'b0;
    end
    bus.start = 1'b0;
    check_eq({tag, "_done_lat"}, 64'(done_at), 64'(n * PER + 1));
    check_eq({tag, "_busy_run"}, 64'(busy_ok), 64'd1);
    check_eq({tag, "_busy_done"}, 64'(bus.busy), 64'd1);
    check_eq({tag, "_mc"}, 64'(bus.mismatch_count), 64'(mc));
    check_eq({tag, "_ffv"}, 64'(bus.first_fail_valid), 64'(ffv));
    check_eq({tag, "_ffi"}, 64'(bus.first_fail_idx), 64'(ffi));
    check_eq({tag, "_sig"}, 64'(bus.signature), 64'(sig));
    @(posedge clk);
    #1;
    check_eq({tag, "_busy_after"}, 64'(bus.busy), 64'd0);
    extra_done = 0;
    for (int k = 0; k < 6; k++) begin
      if (bus.done) extra_done++;
      @(posedge clk);
      #1;
    end
    check_eq({tag, "_extra_done"}, 64'(extra_done), 64'd0);
    check_eq({tag, "_mc_hold"}, 64'(bus.mismatch_count), 64'(mc));
    check_eq({tag, "_sig_hold"}, 64'(bus.signature), 64'(sig));
    if (n > 0) check_eq({tag, "_opa_hold"}, 64'(bus.opnd_a), 64'(ea[n - 1]));
  endtask

  initial begin
    int          mc, ffi, seen_done;
    bit          ffv;
    logic [31:0] sig, sd;
    bus.start       = 1'b0;
    bus.num_vectors = '0;
    bus.seed        = '0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    run(4, 32'd1, -1, -1, "t1");
    run(5, $urandom(), 2, -1, "t2");
    run(0, $urandom(), -1, -1, "t3");
    sd = $urandom();
    run(3, sd, -1, -1, "t4a");
    run(3, sd, -1, -1, "t4b");
    run(3, sd + 32'd1, -1, -1, "t4c");
    run(3, $urandom(), -2, 5, "t6");

    // Reset during SETTLE of vector 3.
    build_model(6, $urandom(), -2, mc, ffv, ffi, sig);
    @(negedge clk);
    bus.start       = 1'b1;
    bus.num_vectors = IW'(6);
    bus.seed        = {ea[0][1:0], eb[0]};
    build_model(6, {ea[0][1:0], eb[0]}, -1, mc, ffv, ffi, sig);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (13) @(posedge clk);
    #1;
    check_eq("t5_opa_v3", 64'(bus.opnd_a), 64'(ea[3]));
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("t5_async");
    seen_done = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (bus.done) seen_done++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (bus.done) seen_done++;
    end
    check_eq("t5_no_done", 64'(seen_done), 64'd0);
    check_zero("t5_after");
    run(4, $urandom(), -2, -1, "t5_rerun");

    for (int r = 0; r < 8; r++) begin
      run($urandom_range(12, 1), $urandom(), -2, -1, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
